// File: rtl/anim_sequencer.sv
// Sprite animation / background scroll sequencer, advanced by vertical-blank pulses.
// Optional macro ANIM_BOUNCE_EN adds a triangle-wave vertical bob on bob_y.
module anim_sequencer #(
   parameter int NUM_FRAMES  = 6,
   parameter int FRAME_DIV   = 4,
   parameter int SCROLL_WRAP = 800,
   parameter int SCROLL_STEP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_data,
   output logic [2:0] anim_frame,
   output logic [9:0] scroll_x,
   output logic [1:0] bob_y,
   output logic       running,
   output logic       update
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_PAUSE = 2'd1,
      ST_STEP  = 2'd2
   } state_t;

   localparam logic [1:0]  OP_RUN       = 2'b00;
   localparam logic [1:0]  OP_PAUSE     = 2'b01;
   localparam logic [1:0]  OP_STEP      = 2'b10;
   localparam logic [1:0]  OP_SET_SPEED = 2'b11;
   localparam logic [3:0]  DIV_LAST     = 4'(FRAME_DIV - 1);
   localparam logic [2:0]  FRAME_LAST   = 3'(NUM_FRAMES - 1);
   localparam logic [10:0] WRAP_VAL     = 11'(SCROLL_WRAP);
   localparam logic [3:0]  SPEED_RST    = 4'(SCROLL_STEP);

   state_t      state_q, state_d;
   logic [3:0]  div_cnt_q, div_cnt_d;
   logic [3:0]  speed_q, speed_d;
   logic [2:0]  anim_q, anim_d;
   logic [9:0]  scroll_q, scroll_d;
   logic        update_q, update_d;
   logic        cmd_fire;
   logic        advance;
   logic [10:0] scroll_sum;
   logic [10:0] scroll_adj;

   // Commands are refused in frame_start cycles so they never race an advance.
   assign cmd_ready = !rst && !frame_start;
   assign cmd_fire  = cmd_valid && cmd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (cmd_fire) begin
         case (cmd_op)
            OP_RUN:   state_d = ST_RUN;
            OP_PAUSE: if (state_q == ST_RUN) state_d = ST_PAUSE;
            OP_STEP:  if (state_q == ST_PAUSE) state_d = ST_STEP;
            default:  state_d = state_q;
         endcase
      end else if (frame_start && state_q == ST_STEP) begin
         state_d = ST_PAUSE;
      end
   end

   always_comb begin
      running = (state_q == ST_RUN);
   end

   always_comb begin
      advance = frame_start &&
                (((state_q == ST_RUN) && (div_cnt_q == DIV_LAST)) || (state_q == ST_STEP));

      div_cnt_d = div_cnt_q;
      if (frame_start) begin
         if (state_q == ST_RUN) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
         end else if (state_q == ST_STEP) begin
            div_cnt_d = 4'd0;
         end
      end

      speed_d = speed_q;
      if (cmd_fire && cmd_op == OP_SET_SPEED) begin
         speed_d = cmd_data;
      end

      // 11-bit sum so the compare against the wrap point cannot overflow.
      scroll_sum = {1'b0, scroll_q} + {7'd0, speed_q};
      scroll_adj = (scroll_sum >= WRAP_VAL) ? scroll_sum - WRAP_VAL : scroll_sum;

      anim_d   = anim_q;
      scroll_d = scroll_q;
      if (advance) begin
         anim_d   = (anim_q == FRAME_LAST) ? 3'd0 : anim_q + 3'd1;
         scroll_d = scroll_adj[9:0];
      end

      update_d = advance;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= 4'd0;
         speed_q   <= SPEED_RST;
         anim_q    <= 3'd0;
         scroll_q  <= 10'd0;
         update_q  <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         speed_q   <= speed_d;
         anim_q    <= anim_d;
         scroll_q  <= scroll_d;
         update_q  <= update_d;
      end
   end

   assign anim_frame = anim_q;
   assign scroll_x   = scroll_q;
   assign update     = update_q;

`ifdef ANIM_BOUNCE_EN
   logic [1:0] bob_q, bob_d;
   logic       bob_up_q, bob_up_d;

   // Triangle wave 0,1,2,3,2,1,0,... turning around at both ends.
   always_comb begin
      bob_d    = bob_q;
      bob_up_d = bob_up_q;
      if (advance) begin
         if (bob_up_q) begin
            if (bob_q == 2'd3) begin
               bob_d    = 2'd2;
               bob_up_d = 1'b0;
            end else begin
               bob_d = bob_q + 2'd1;
            end
         end else begin
            if (bob_q == 2'd0) begin
               bob_d    = 2'd1;
               bob_up_d = 1'b1;
            end else begin
               bob_d = bob_q - 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bob_q    <= 2'd0;
         bob_up_q <= 1'b1;
      end else begin
         bob_q    <= bob_d;
         bob_up_q <= bob_up_d;
      end
   end

   assign bob_y = bob_q;
`else
   assign bob_y = 2'd0;
`endif

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer: a vector table for the steady-state behaviour
// plus hand sequences for scroll wrap, held commands, resets and bob_y.
module tb_anim_sequencer;

   logic       clk;
   logic       rst;
   logic       frame_start;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic [2:0] anim_frame;
   logic [9:0] scroll_x;
   logic [1:0] bob_y;
   logic       running;
   logic       update;

   int vectorsApplied = 0;
   int miscompares    = 0;
   int updCnt         = 0;

   localparam logic [1:0] OP_RUN   = 2'b00;
   localparam logic [1:0] OP_PAUSE = 2'b01;
   localparam logic [1:0] OP_STEP  = 2'b10;
   localparam logic [1:0] OP_SPEED = 2'b11;

   typedef struct {
      logic       hasCmd;
      logic [1:0] op;
      logic [3:0] data;
      int         numFs;
      int         expAnim;
      int         expScroll;
      int         expRun;
      int         expUpd;
   } vec_t;

   vec_t vecs[17];

   anim_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_data    (cmd_data),
      .anim_frame  (anim_frame),
      .scroll_x    (scroll_x),
      .bob_y       (bob_y),
      .running     (running),
      .update      (update)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts update pulses; each pulse is high for exactly one negedge.
   always @(negedge clk) begin
      if (update === 1'b1) updCnt = updCnt + 1;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectorsApplied++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic sendCmd(input logic [1:0] op, input logic [3:0] data);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic pulseFrame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int idx);
      updCnt = 0;
      if (vecs[idx].hasCmd) sendCmd(vecs[idx].op, vecs[idx].data);
      for (int f = 0; f < vecs[idx].numFs; f++) pulseFrame();
      settle();
      checkOutput($sformatf("v%0d anim_frame", idx), int'(anim_frame), vecs[idx].expAnim);
      checkOutput($sformatf("v%0d scroll_x", idx), int'(scroll_x), vecs[idx].expScroll);
      checkOutput($sformatf("v%0d running", idx), int'(running), vecs[idx].expRun);
      checkOutput($sformatf("v%0d updates", idx), updCnt, vecs[idx].expUpd);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " anim_frame"}, int'(anim_frame), 0);
      checkOutput({tag, " scroll_x"}, int'(scroll_x), 0);
      checkOutput({tag, " bob_y"}, int'(bob_y), 0);
      checkOutput({tag, " update"}, int'(update), 0);
      checkOutput({tag, " cmd_ready"}, int'(cmd_ready), 0);
      checkOutput({tag, " running"}, int'(running), 1);
   endtask

   // Reset asserted between clock edges; outputs must clear before any edge.
   task automatic asyncReset(input string tag);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkResetValues(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int bobExp[7];
`ifdef ANIM_BOUNCE_EN
      bobExp = '{1, 2, 3, 2, 1, 0, 1};
`else
      bobExp = '{0, 0, 0, 0, 0, 0, 0};
`endif

      //            cmd   op        data  fs  anim scroll run upd
      vecs[0]  = '{1'b0, OP_RUN,   4'd0,  3,  0,   0,    1,  0};
      vecs[1]  = '{1'b0, OP_RUN,   4'd0,  1,  1,   2,    1,  1};
      vecs[2]  = '{1'b0, OP_RUN,   4'd0,  4,  2,   4,    1,  1};
      vecs[3]  = '{1'b1, OP_SPEED, 4'd5,  2,  2,   4,    1,  0};
      vecs[4]  = '{1'b0, OP_RUN,   4'd0,  2,  3,   9,    1,  1};
      vecs[5]  = '{1'b1, OP_PAUSE, 4'd0, 10,  3,   9,    0,  0};
      vecs[6]  = '{1'b1, OP_STEP,  4'd0,  1,  4,  14,    0,  1};
      vecs[7]  = '{1'b0, OP_RUN,   4'd0,  3,  4,  14,    0,  0};
      vecs[8]  = '{1'b1, OP_STEP,  4'd0,  0,  4,  14,    0,  0};
      vecs[9]  = '{1'b1, OP_STEP,  4'd0,  1,  5,  19,    0,  1};
      vecs[10] = '{1'b1, OP_RUN,   4'd0,  0,  5,  19,    1,  0};
      vecs[11] = '{1'b0, OP_RUN,   4'd0,  4,  0,  24,    1,  1};
      vecs[12] = '{1'b1, OP_SPEED, 4'd0,  4,  1,  24,    1,  1};
      vecs[13] = '{1'b0, OP_RUN,   4'd0,  2,  1,  24,    1,  0};
      vecs[14] = '{1'b1, OP_PAUSE, 4'd0,  5,  1,  24,    0,  0};
      vecs[15] = '{1'b1, OP_RUN,   4'd0,  2,  2,  24,    1,  1};
      vecs[16] = '{1'b1, OP_RUN,   4'd0,  0,  2,  24,    1,  0};

      rst         = 1'b1;
      frame_start = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 2'b00;
      cmd_data    = 4'd0;
      #1;
      checkResetValues("power-on reset");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("cmd_ready after release", int'(cmd_ready), 1);

      for (int i = 0; i < 17; i++) applyStimulus(i);

      // Walk scroll_x up to 796 with single steps, then cross the wrap point.
      sendCmd(OP_SPEED, 4'd15);
      sendCmd(OP_PAUSE, 4'd0);
      for (int s = 0; s < 51; s++) begin
         sendCmd(OP_STEP, 4'd0);
         pulseFrame();
      end
      settle();
      checkOutput("scroll_x after 51 steps", int'(scroll_x), 789);
      sendCmd(OP_SPEED, 4'd7);
      sendCmd(OP_STEP, 4'd0);
      pulseFrame();
      settle();
      checkOutput("scroll_x at 796", int'(scroll_x), 796);
      checkOutput("anim_frame at 796", int'(anim_frame), 0);
      sendCmd(OP_STEP, 4'd0);
      pulseFrame();
      settle();
      checkOutput("scroll_x wrapped", int'(scroll_x), 3);
      checkOutput("anim_frame wrapped step", int'(anim_frame), 1);
      checkOutput("running while paused", int'(running), 0);
      sendCmd(OP_SPEED, 4'd0);
      updCnt = 0;
      sendCmd(OP_STEP, 4'd0);
      pulseFrame();
      settle();
      checkOutput("speed0 scroll_x", int'(scroll_x), 3);
      checkOutput("speed0 anim_frame", int'(anim_frame), 2);
      checkOutput("speed0 updates", updCnt, 1);

      // RUN command held across a frame_start cycle.
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_op      = OP_RUN;
      cmd_data    = 4'd0;
      frame_start = 1'b1;
      #1;
      checkOutput("cmd_ready during frame_start", int'(cmd_ready), 0);
      @(negedge clk);
      frame_start = 1'b0;
      #1;
      checkOutput("cmd_ready after frame_start", int'(cmd_ready), 1);
      checkOutput("running before accept", int'(running), 0);
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      checkOutput("running after held RUN", int'(running), 1);

      // Reset in the middle of a divider count.
      for (int f = 0; f < 3; f++) pulseFrame();
      asyncReset("reset mid-count");
      updCnt = 0;
      for (int f = 0; f < 3; f++) pulseFrame();
      settle();
      checkOutput("post-reset 3 fs updates", updCnt, 0);
      pulseFrame();
      settle();
      checkOutput("post-reset 4 fs updates", updCnt, 1);
      checkOutput("post-reset anim_frame", int'(anim_frame), 1);
      checkOutput("post-reset scroll_x", int'(scroll_x), 2);

      // Reset with a step pending.
      sendCmd(OP_PAUSE, 4'd0);
      sendCmd(OP_STEP, 4'd0);
      asyncReset("reset mid-step");
      updCnt = 0;
      pulseFrame();
      settle();
      checkOutput("mid-step reset no advance", updCnt, 0);
      checkOutput("mid-step reset running", int'(running), 1);
      for (int f = 0; f < 3; f++) pulseFrame();
      settle();
      checkOutput("mid-step reset 4th fs updates", updCnt, 1);
      checkOutput("mid-step reset anim_frame", int'(anim_frame), 1);

      // Seven advances from reset: update timing, anim_frame and bob_y.
      asyncReset("reset before bob run");
      for (int k = 0; k < 7; k++) begin
         for (int f = 0; f < 3; f++) pulseFrame();
         @(negedge clk);
         frame_start = 1'b1;
         #1;
         if (k == 0) checkOutput("update low in frame_start cycle", int'(update), 0);
         @(negedge clk);
         frame_start = 1'b0;
         #1;
         checkOutput($sformatf("adv%0d update", k), int'(update), 1);
         checkOutput($sformatf("adv%0d anim_frame", k), int'(anim_frame), (k + 1) % 6);
         checkOutput($sformatf("adv%0d bob_y", k), int'(bob_y), bobExp[k]);
         @(negedge clk);
         #1;
         if (k == 0) checkOutput("update one cycle only", int'(update), 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
